// File: rtl/wb_regfile_if.sv
// wb_regfile_if: write-back buffer inputs and register-file read ports.
// master drives the buffer and read addresses, slave is the register file.
interface wb_regfile_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              write_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] alu_data;
    logic [DATA_W-1:0] mem_data;
    logic              mem_reg;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] dbg_data;
    logic [DATA_W-1:0] wb_data;
    logic [15:0]       wb_count;

    modport master (
        output write_en,
        output wr_addr,
        output alu_data,
        output mem_data,
        output mem_reg,
        output rs_addr,
        output rt_addr,
        output dbg_addr,
        input  rs_data,
        input  rt_data,
        input  dbg_data,
        input  wb_data,
        input  wb_count
    );

    modport slave (
        input  write_en,
        input  wr_addr,
        input  alu_data,
        input  mem_data,
        input  mem_reg,
        input  rs_addr,
        input  rt_addr,
        input  dbg_addr,
        output rs_data,
        output rt_data,
        output dbg_data,
        output wb_data,
        output wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back mux, 16-entry register file (R0 = 0), commit counter.
// Define WB_BYPASS_EN for write-through bypass on the rs/rt read ports.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    wb_regfile_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [15:0]       r_wb_count;

    logic [DATA_W-1:0] w_wb_data;
    logic              w_commit;
    logic [DATA_W-1:0] w_rs_raw;
    logic [DATA_W-1:0] w_rt_raw;
    logic [DATA_W-1:0] w_dbg_raw;

    // select write-back source; the unused side never reaches the output
    always_comb begin
        w_wb_data = bus.mem_reg ? bus.alu_data : bus.mem_data;
    end

    // a write only commits when live, out of reset and not aimed at R0
    always_comb begin
        w_commit = !rst && bus.write_en && (bus.wr_addr != '0);
    end

    // register array: synchronous clear, otherwise commit the selected value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[bus.wr_addr] <= w_wb_data;
        end
    end

    // count committed writes; wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_count <= '0;
        end else if (w_commit) begin
            r_wb_count <= r_wb_count + 16'd1;
        end
    end

    // raw array reads with R0 forced to zero on every port
    always_comb begin
        w_rs_raw  = (bus.rs_addr  == '0) ? '0 : r_regs[bus.rs_addr];
        w_rt_raw  = (bus.rt_addr  == '0) ? '0 : r_regs[bus.rt_addr];
        w_dbg_raw = (bus.dbg_addr == '0) ? '0 : r_regs[bus.dbg_addr];
    end

`ifdef WB_BYPASS_EN
    logic w_hit_rs;
    logic w_hit_rt;

    // forward the committing value to a decode port reading the same register
    always_comb begin
        w_hit_rs    = w_commit && (bus.rs_addr == bus.wr_addr);
        w_hit_rt    = w_commit && (bus.rt_addr == bus.wr_addr);
        bus.rs_data = w_hit_rs ? w_wb_data : w_rs_raw;
        bus.rt_data = w_hit_rt ? w_wb_data : w_rt_raw;
    end
`else
    // decode ports see stored contents only; new value appears next cycle
    always_comb begin
        bus.rs_data = w_rs_raw;
        bus.rt_data = w_rt_raw;
    end
`endif

    assign bus.dbg_data = w_dbg_raw;
    assign bus.wb_data  = w_wb_data;
    assign bus.wb_count = r_wb_count;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and random checks of wb_regfile against an array model.
// Build with +define+WB_BYPASS_EN to check the bypass variant.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    wb_regfile #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    bit run    = 1'b0;

    logic [15:0] m_regs [16];
    logic [15:0] m_cnt;

    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_cnt = '0;
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_wb();
        return bus.mem_reg ? bus.alu_data : bus.mem_data;
    endfunction

    function automatic logic [15:0] m_port(input logic [3:0] a);
        if (a == 4'd0) return 16'h0000;
`ifdef WB_BYPASS_EN
        if (!rst && bus.write_en && bus.wr_addr == a) return m_wb();
`endif
        return m_regs[a];
    endfunction

    // reference model: the architectural register file and counter
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_cnt = '0;
        end else if (bus.write_en && bus.wr_addr != 4'd0) begin
            m_regs[bus.wr_addr] = m_wb();
            m_cnt = m_cnt + 16'd1;
        end
    end

    // compare every output against the model each cycle
    always @(negedge clk) begin
        if (run) begin
            chk("rs_data", bus.rs_data, m_port(bus.rs_addr));
            chk("rt_data", bus.rt_data, m_port(bus.rt_addr));
            chk("dbg_data", bus.dbg_data,
                (bus.dbg_addr == 4'd0) ? 16'h0000 : m_regs[bus.dbg_addr]);
            chk("wb_data", bus.wb_data, m_wb());
            chk("wb_count", bus.wb_count, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write_en = 1'b0;
        bus.wr_addr  = 4'd0;
        bus.alu_data = 16'h0000;
        bus.mem_data = 16'h0000;
        bus.mem_reg  = 1'b1;
    endtask

    task automatic rand_in();
        bus.write_en = 1'($urandom_range(0, 1));
        bus.wr_addr  = 4'($urandom_range(0, 15));
        bus.alu_data = 16'($urandom);
        bus.mem_data = 16'($urandom);
        bus.mem_reg  = 1'($urandom_range(0, 1));
        bus.rs_addr  = ($urandom_range(0, 2) == 0) ? bus.wr_addr
                                                   : 4'($urandom_range(0, 15));
        bus.rt_addr  = ($urandom_range(0, 2) == 0) ? bus.wr_addr
                                                   : 4'($urandom_range(0, 15));
        bus.dbg_addr = 4'($urandom_range(0, 15));
    endtask

    logic [15:0] hz_exp;

    initial begin
        rst = 1'b1;
        idle();
        bus.rs_addr  = 4'd0;
        bus.rt_addr  = 4'd0;
        bus.dbg_addr = 4'd0;
        repeat (2) step();
        rst = 1'b0;
        run = 1'b1;

        // fill with random data, then reset for 2 cycles
        repeat (20) begin
            rand_in();
            step();
        end
        rst = 1'b1;
        repeat (2) begin
            rand_in();
            step();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 16; i++) begin
            bus.rs_addr  = 4'(i);
            bus.rt_addr  = 4'(i);
            bus.dbg_addr = 4'(i);
            @(negedge clk);
            chk("rst_rs", bus.rs_data, 16'h0000);
            chk("rst_rt", bus.rt_data, 16'h0000);
            chk("rst_dbg", bus.dbg_data, 16'h0000);
            step();
        end
        @(negedge clk);
        chk("rst_cnt", bus.wb_count, 16'h0000);
        step();

        // ALU write-back
        bus.write_en = 1'b1;
        bus.wr_addr  = 4'h3;
        bus.mem_reg  = 1'b1;
        bus.alu_data = 16'hBEEF;
        bus.mem_data = 16'h1234;
        @(negedge clk);
        chk("alu_wb", bus.wb_data, 16'hBEEF);
        step();
        idle();
        bus.rs_addr = 4'h3;
        @(negedge clk);
        chk("alu_rd", bus.rs_data, 16'hBEEF);
        chk("alu_cnt", bus.wb_count, 16'h0001);
        step();

        // memory write-back
        bus.write_en = 1'b1;
        bus.wr_addr  = 4'hA;
        bus.mem_reg  = 1'b0;
        bus.alu_data = 16'h0F0F;
        bus.mem_data = 16'h5A5A;
        @(negedge clk);
        chk("mem_wb", bus.wb_data, 16'h5A5A);
        step();
        idle();
        bus.rt_addr = 4'hA;
        @(negedge clk);
        chk("mem_rd", bus.rt_data, 16'h5A5A);
        chk("mem_cnt", bus.wb_count, 16'h0002);
        step();

        // R0 protection
        bus.write_en = 1'b1;
        bus.wr_addr  = 4'h0;
        bus.mem_reg  = 1'b1;
        bus.alu_data = 16'hFFFF;
        bus.rs_addr  = 4'h0;
        @(negedge clk);
        chk("r0_same", bus.rs_data, 16'h0000);
        step();
        idle();
        @(negedge clk);
        chk("r0_rd", bus.rs_data, 16'h0000);
        chk("r0_cnt", bus.wb_count, 16'h0002);
        step();

        // same-cycle read/write hazard on reg5
        bus.write_en = 1'b1;
        bus.wr_addr  = 4'h5;
        bus.mem_reg  = 1'b1;
        bus.alu_data = 16'h0001;
        step();
        bus.alu_data = 16'h0002;
        bus.rs_addr  = 4'h5;
        bus.dbg_addr = 4'h5;
`ifdef WB_BYPASS_EN
        hz_exp = 16'h0002;
`else
        hz_exp = 16'h0001;
`endif
        @(negedge clk);
        chk("hz_rs", bus.rs_data, hz_exp);
        chk("hz_dbg", bus.dbg_data, 16'h0001);
        step();
        idle();
        @(negedge clk);
        chk("hz_next", bus.rs_data, 16'h0002);
        chk("hz_cnt", bus.wb_count, 16'h0004);
        step();

        // flush bubbles
        repeat (3) begin
            idle();
            @(negedge clk);
            chk("flush_wb", bus.wb_data, 16'h0000);
            step();
        end
        @(negedge clk);
        chk("flush_cnt", bus.wb_count, 16'h0004);
        chk("flush_r5", bus.rs_data, 16'h0002);
        step();

        // random traffic with occasional resets
        repeat (1500) begin
            rand_in();
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;

        // counter wrap: 65535 commits, then one more
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        repeat (65535) begin
            bus.write_en = 1'b1;
            bus.wr_addr  = 4'($urandom_range(1, 15));
            bus.alu_data = 16'($urandom);
            bus.mem_data = 16'($urandom);
            bus.mem_reg  = 1'($urandom_range(0, 1));
            step();
        end
        idle();
        @(negedge clk);
        chk("cnt_max", bus.wb_count, 16'hFFFF);
        step();
        bus.write_en = 1'b1;
        bus.wr_addr  = 4'h7;
        bus.alu_data = 16'h1357;
        step();
        idle();
        @(negedge clk);
        chk("cnt_wrap", bus.wb_count, 16'h0000);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the execute/accumulator pipeline buffer for the 16-bit MIPS datapath.
- Consumes the buffered result word, destination register, write enable and mem/ALU select from that buffer.
- Selects the write-back value and commits it to a 16-entry register file.
- Serves two combinational operand read ports to decode, plus one debug read port.

Parameters:
- DATA_W, 16, register and data-path width in bits
- ADDR_W, 4, register address width; depth = 2**ADDR_W = 16 entries

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- write_en  input  1  write enable from the pipeline buffer
- wr_addr  input  ADDR_W  destination register from the pipeline buffer
- alu_data  input  DATA_W  buffered ALU/accumulator result
- mem_data  input  DATA_W  load data returned from data memory
- mem_reg  input  1  write-back source select: 1 = alu_data, 0 = mem_data
- rs_addr  input  ADDR_W  read port A address
- rt_addr  input  ADDR_W  read port B address
- dbg_addr  input  ADDR_W  debug read address
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- dbg_data  output  DATA_W  debug read data (raw array, never bypassed)
- wb_data  output  DATA_W  selected write-back value (combinational, for forwarding into execute)
- wb_count  output  16  committed-write counter

Behaviour:
- Write-back mux:
  - wb_data = mem_reg ? alu_data : mem_data.
  - The buffer's flush state (data 0, addr 0, en 0, mem_reg 1) therefore yields wb_data = 0.
- Commit:
  - On the rising edge of clk, if !rst && write_en && wr_addr != 0, then reg[wr_addr] <= wb_data.
  - Write latency is 1 cycle; the new value is visible in the array from the next cycle.
- R0 is hardwired to zero:
  - Writes to address 0 are discarded and do not increment wb_count.
  - Reads of address 0 return 0 on every port.
- Reads:
  - rs_data, rt_data and dbg_data are combinational, with no read latency.
  - dbg_data always reflects array contents only.
- wb_count:
  - Increments by 1 on every committed write (write_en=1, wr_addr!=0).
  - Wraps from 16'hFFFF to 16'h0000 and saturates never.
- Reset (synchronous):
  - While rst=1 at a rising edge, all 16 registers and wb_count are cleared to 0.
  - Any coincident write is dropped.
  - rs_data, rt_data and dbg_data read 0 from the cycle after reset is sampled.
  - wb_data stays combinational and follows its inputs during reset.
- Reset mid-operation: the write presented in the reset cycle is lost; no partial update occurs.
- Simultaneous read and write to the same address: behaviour is set by the optional feature below.
- Both read ports may address the same register; both return the identical value.
- The X/unknown value of mem_data when mem_reg=1 must not propagate (the mux isolates it).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Write-through bypass on rs_data and rt_data.
  - If write_en=1, wr_addr!=0 and the port address equals wr_addr in the same cycle, the port returns wb_data instead of the stored value.
  - Decode therefore sees the value committing this cycle, with no extra stall.
  - dbg_data is not bypassed.
  - Bypass is suppressed while rst=1.
- Not defined: read ports return the array contents only, so the old value is returned in the write cycle and the new value on the next cycle.

Test Plan:
- Reset: rst=1 for 2 cycles after writes of random data -> all of rs_data/rt_data/dbg_data for addresses 0..15 read 16'h0000; wb_count = 0.
- ALU write-back: write_en=1, wr_addr=4'h3, mem_reg=1, alu_data=16'hBEEF, mem_data=16'h1234 -> next cycle rs_addr=3 gives 16'hBEEF; wb_count=1.
- Memory write-back: write_en=1, wr_addr=4'hA, mem_reg=0, mem_data=16'h5A5A -> next cycle rt_addr=A gives 16'h5A5A; wb_data=16'h5A5A in the write cycle.
- R0 protection: write_en=1, wr_addr=0, alu_data=16'hFFFF -> rs_addr=0 reads 16'h0000; wb_count unchanged.
- Same-cycle hazard: reg5 holds 16'h0001; write 16'h0002 to reg5 while rs_addr=5 ->
  - with WB_BYPASS_EN: rs_data=16'h0002 in that cycle;
  - without WB_BYPASS_EN: rs_data=16'h0001, then 16'h0002 next cycle;
  - in both builds dbg_data=16'h0001 in that cycle.
- Flush bubble and counter wrap:
  - Buffer flush values (en 0, addr 0, data 0, mem_reg 1) for 3 cycles -> no register changes, wb_count stable.
  - Preload wb_count via 65535 commits, then 1 more -> wb_count = 16'h0000.
